// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, default datapath sizes and a
// counter-width helper for the multi-cycle adder.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width for n slices; a single-slice build still needs a 1-bit counter.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top
// bit so the caller can derive signed overflow on the most significant slice.
module adder_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             carryIn,
  output logic [CHUNK-1:0] result,
  output logic             carryOut,
  output logic             msbCarryIn
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = carryIn;

  for (genvar g = 0; g < CHUNK; g++) begin : g_bit
    full_adder u_fa (
      .i_a   (A[g]),
      .i_b   (B[g]),
      .i_cin (w_c[g]),
      .o_sum (result[g]),
      .o_cout(w_c[g+1])
    );
  end

  assign carryOut   = w_c[CHUNK];
  assign msbCarryIn = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the slice ripple chain.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/adder_multicycle.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock through a single
// shared slice adder, with start/ready/done handshake and registered flags.
module adder_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NSLICES = WIDTH / CHUNK;
  localparam int CW      = clog2_min1(NSLICES);
  localparam logic [CW-1:0] K_LAST = CW'(NSLICES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [CW-1:0]    r_k;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_accept = start & ready;
  assign w_last   = (r_k == K_LAST);
  assign w_a_sl   = r_a[int'(r_k)*CHUNK +: CHUNK];
  assign w_b_sl   = r_b[int'(r_k)*CHUNK +: CHUNK];

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .A         (w_a_sl),
    .B         (w_b_sl),
    .carryIn   (r_c),
    .result    (w_sum),
    .carryOut  (w_cout),
    .msbCarryIn(w_msb_cin)
  );

  // Accumulator with the current slice merged in; on the last slice this is the full result.
  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[int'(r_k)*CHUNK +: CHUNK] = w_sum;
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;  else w_state_nxt = ST_IDLE;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE; else w_state_nxt = ST_RUN;
      ST_DONE: if (w_accept) w_state_nxt = ST_RUN;  else w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Controller state, handshake outputs and slice datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      ready   <= (w_state_nxt != ST_RUN);
      done    <= (w_state_nxt == ST_DONE);
      // Subtraction runs as A + ~B + ~borrow through the same adder.
      if (w_accept) begin
        r_a <= A;
        r_b <= subtract ? ~B : B;
        r_c <= carryIn ^ subtract;
        r_k <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_acc_nxt;
        r_c   <= w_cout;
        r_k   <= r_k + CW'(1);
      end
    end
  end

  // Result and flags load only on the final slice and hold until the next completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result   <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      result   <= w_acc_nxt;
      carryOut <= w_cout;
      overflow <= w_msb_cin ^ w_cout;
      zero     <= (w_acc_nxt == '0);
      negative <= w_acc_nxt[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_adder_multicycle.sv
// Scoreboard bench for adder_multicycle in three slice configurations
// (CHUNK = 8, 32, 1) against an integer-arithmetic reference model.
module tb_adder_multicycle;

  localparam int NI = 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMOD = 64'sd4294967296;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        zr;
    logic        ng;
  } out_t;

  typedef struct {
    out_t o;
    int   t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        st[NI], sb[NI], ci[NI], rdy[NI], dn[NI], co[NI], ov[NI], zr[NI], ng[NI];
  logic [31:0] a[NI], b[NI], res[NI];
  exp_t        exp_q[NI][$];
  out_t        held[NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_multicycle #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clock(clk), .reset(rst_n), .start(st[0]), .subtract(sb[0]), .A(a[0]), .B(b[0]),
    .carryIn(ci[0]), .ready(rdy[0]), .done(dn[0]), .result(res[0]), .carryOut(co[0]),
    .overflow(ov[0]), .zero(zr[0]), .negative(ng[0]));

  adder_multicycle #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clock(clk), .reset(rst_n), .start(st[1]), .subtract(sb[1]), .A(a[1]), .B(b[1]),
    .carryIn(ci[1]), .ready(rdy[1]), .done(dn[1]), .result(res[1]), .carryOut(co[1]),
    .overflow(ov[1]), .zero(zr[1]), .negative(ng[1]));

  adder_multicycle #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clock(clk), .reset(rst_n), .start(st[2]), .subtract(sb[2]), .A(a[2]), .B(b[2]),
    .carryIn(ci[2]), .ready(rdy[2]), .done(dn[2]), .result(res[2]), .carryOut(co[2]),
    .overflow(ov[2]), .zero(zr[2]), .negative(ng[2]));

  function automatic int nsl(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference: exact unsigned and signed integer results, then range tests.
  function automatic out_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic c);
    longint uv, sv;
    out_t   o;
    if (s) begin
      uv   = longint'(x) - longint'(y) - longint'(c);
      sv   = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
      o.co = (uv >= 0);
    end else begin
      uv   = longint'(x) + longint'(y) + longint'(c);
      sv   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      o.co = (uv >= UMOD);
    end
    o.res = uv[31:0];
    o.ov  = (sv > SMAX) || (sv < SMIN);
    o.zr  = (o.res == 32'd0);
    o.ng  = o.res[31];
    return o;
  endfunction

  function automatic out_t cur_out(input int i);
    return {res[i], co[i], ov[i], zr[i], ng[i]};
  endfunction

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL dut%0d %s actual=%0h expected=%0h (t=%0t)", i, nm, act, expv, $time);
    end
  endtask

  task automatic timeout(input int i, input string nm);
    checks++;
    errors++;
    $display("FAIL dut%0d %s timeout (t=%0t)", i, nm, $time);
  endtask

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic issue(input int i, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input logic c, input int hold);
    int n = 0;
    while (!rdy[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      timeout(i, "wait_ready");
      return;
    end
    st[i] = 1'b1; a[i] = x; b[i] = y; sb[i] = s; ci[i] = c;
    @(posedge clk);
    #1;
    exp_q[i].push_back('{model(x, y, s, c), cyc});
    a[i] = $urandom; b[i] = $urandom;
    sb[i] = 1'($urandom_range(0, 1)); ci[i] = 1'($urandom_range(0, 1));
    if (hold == 0) st[i] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      a[i] = $urandom; b[i] = $urandom;
    end
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (exp_q[i].size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[i].size() != 0) timeout(i, "drain");
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic rand_ops(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(i, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    wait_idle(i);
  endtask

  // Monitor: pops the scoreboard on done and checks outputs hold otherwise.
  initial begin
    exp_t e;
    out_t cur;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        cur = cur_out(i);
        if (!rst_n) begin
          held[i] = '0;
        end else if (dn[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_done result=%0h (t=%0t)", i, cur.res, $time);
          end else begin
            e = exp_q[i].pop_front();
            chk(i, "result",   64'(cur.res), 64'(e.o.res));
            chk(i, "carryOut", 64'(cur.co),  64'(e.o.co));
            chk(i, "overflow", 64'(cur.ov),  64'(e.o.ov));
            chk(i, "zero",     64'(cur.zr),  64'(e.o.zr));
            chk(i, "negative", 64'(cur.ng),  64'(e.o.ng));
            chk(i, "latency",  64'(cyc - e.t_acc), 64'(nsl(i)));
          end
          held[i] = cur;
        end else begin
          chk(i, "hold", 64'(cur), 64'(held[i]));
        end
      end
    end
  end

  initial begin
    int t1, t2, n;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0; sb[i] = 1'b0; ci[i] = 1'b0; a[i] = 32'd0; b[i] = 32'd0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk(i, "reset_ready", 64'(rdy[i]), 64'd1);
      chk(i, "reset_done",  64'(dn[i]),  64'd0);
      chk(i, "reset_outs",  64'(cur_out(i)), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First add with explicit handshake timing.
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    chk(0, "ready_run0", 64'(rdy[0]), 64'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk(0, "ready_run", 64'(rdy[0]), 64'd0);
    end
    @(negedge clk);
    chk(0, "ready_done", 64'(rdy[0]), 64'd1);
    chk(0, "done_pulse", 64'(dn[0]),  64'd1);
    chk(0, "add_result", 64'(res[0]), 64'h100);
    @(negedge clk);

    // Carry/zero, signed overflow, subtract and subtract-overflow corners.
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    issue(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 0);
    issue(0, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0);
    issue(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0);
    wait_idle(0);

    // start held high with operands changing during RUN must be ignored.
    issue(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 4);
    wait_idle(0);

    // Back-to-back: accept in the DONE cycle, second done 5 cycles later.
    issue(0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 0);
    n = 0;
    while (!dn[0] && n < 50) begin @(negedge clk); n++; end
    if (!dn[0]) timeout(0, "b2b_first");
    t1 = cyc;
    issue(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 0);
    n = 0;
    while (!dn[0] && n < 50) begin @(negedge clk); n++; end
    if (!dn[0]) timeout(0, "b2b_second");
    t2 = cyc;
    chk(0, "b2b_gap", 64'(t2 - t1), 64'd5);
    wait_idle(0);

    // Reset mid-run: outputs clear at once and the aborted op never completes.
    issue(0, 32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "abort_ready", 64'(rdy[0]), 64'd1);
    chk(0, "abort_done",  64'(dn[0]),  64'd0);
    chk(0, "abort_outs",  64'(cur_out(0)), 64'd0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 0);
    wait_idle(0);

    // Random traffic on all three configurations in parallel.
    fork
      rand_ops(0, 60);
      rand_ops(1, 80);
      rand_ops(2, 30);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_multicycle.md
Name: adder_multicycle

Overview:
- Parametrised multi-cycle adder/subtractor for the ALU. It is the successor to the fixed 32-bit ripple adder.
- Adds or subtracts WIDTH-bit operands one CHUNK-bit slice per clock, with a start/ready/done handshake.
- Produces registered result plus carry, overflow, zero and negative flags.
- Trades latency for a short carry chain: the critical path is one CHUNK-bit ripple.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NSLICES, WIDTH/CHUNK, derived localparam; latency in cycles.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted when start=1 and ready=1.
- subtract  input  1  0: A+B+carryIn; 1: A-B-carryIn (borrow).
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- carryIn  input  1  carry (add) or borrow (subtract), sampled on accept.
- ready  output  1  block can accept a new operation.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  sum/difference, registered.
- carryOut  output  1  carry out of MSB (for subtract: 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ready=1; done=0; result=0; carryOut=overflow=zero=negative=0; slice counter=0. The reset takes effect immediately and aborts any operation in flight; no done is produced for the aborted operation.
- States:
  - IDLE: ready=1. Accept moves to RUN.
  - RUN: ready=0. One slice processed per edge.
  - DONE: ready=1, done=1 for exactly one cycle. Accept moves to RUN; otherwise go to IDLE.
- Accept edge:
  - Latch A.
  - Latch Beff = subtract ? ~B : B.
  - Initial carry c = carryIn XOR subtract.
  - Clear slice counter k.
- RUN edge for slice k (k = 0..NSLICES-1):
  - acc[k*CHUNK +: CHUNK] = A_slice + Beff_slice + c.
  - c gets the slice carry-out.
  - On the last slice, also capture the carry into the MSB.
- After the edge processing slice NSLICES-1, state becomes DONE. On that same edge the output registers load:
  - result = acc;
  - carryOut = final c;
  - overflow = carry into MSB XOR carry out of MSB;
  - zero = (acc == 0);
  - negative = acc[MSB].
- Latency: accept on edge E0 gives done=1 in the cycle after edge E(NSLICES). With WIDTH=CHUNK, done follows one edge after accept.
- Output hold: result and flags hold their values from the done cycle until the next completion. They do not change during a subsequent RUN.
- start while ready=0: ignored, no side effect; operands on the bus are not sampled.
- Back-to-back: start during DONE is accepted, so a new RUN begins the next cycle and throughput is one op per NSLICES+1 cycles.
- Operand inputs may change freely after accept.
- Arithmetic is modulo 2^WIDTH.
- Overflow is defined for two's-complement interpretation of A, B and result.

Decomposition:
- Shared package alu_pkg:
  - FSM state encoding constants: ST_IDLE, ST_RUN, ST_DONE.
  - Default WIDTH/CHUNK constants.
- Sub-module adder_slice:
  - Parametrised CHUNK-bit combinational ripple adder built from the existing full_adder cell.
  - Ports: A, B, carryIn, result, carryOut, plus msbCarryIn (carry into the top bit) for overflow.
  - Instantiated once and reused every cycle through the slice-select mux.
- The counter width is clog2(NSLICES), minimum 1.

Test Plan (WIDTH=32, CHUNK=8 unless noted; NSLICES=4):
- Add: A=0x000000FF, B=0x00000001, cin=0, start at E0 -> done pulse in the cycle after E4; result=0x00000100; carryOut=0, overflow=0, zero=0, negative=0; ready=0 during E1..E4.
- Carry/zero: A=0xFFFFFFFF, B=0x00000001 -> result=0, carryOut=1, zero=1, overflow=0. Signed overflow: A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1, negative=1, carryOut=0.
- Subtract: A=5, B=7, sub=1, cin=0 -> result=0xFFFFFFFE, carryOut=0, negative=1. A=7, B=5, sub=1, cin=1 -> result=1, carryOut=1. Subtract overflow: A=0x80000000, B=1 -> 0x7FFFFFFF, overflow=1.
- Handshake: start held high with changing A/B during RUN -> ignored; result matches the operands latched at accept. start asserted in the DONE cycle -> accepted; second done exactly 5 cycles after the first; result holds the first value until the second done.
- Reset mid-run: drop reset after E2 -> all outputs 0 and ready=1 immediately (before the next edge); no done. A fresh op after release completes normally.
- Parameter sweep: CHUNK=32 -> done one edge after accept. CHUNK=1 -> latency 32. Random A/B/sub/cin checked against a WIDTH+1-bit reference model for both configs.
